// File: rtl/riscv_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings and the
// outstanding-load FIFO entry layout.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] offset;
    } ld_entry_t;

    // One-hot register mask; x0 is hardwired so it never shows as pending.
    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        logic [31:0] mask;
        mask     = 32'd1 << rd;
        mask[0]  = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load data alignment: selects the byte/halfword lane from the
// raw memory word and sign- or zero-extends it to 32 bits.
module riscv_load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfword lane uses offset[1] only; a misaligned offset[0] is dropped.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            F3_LW:   data = rdata;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_writeback.sv
// Writeback stage: arbitrates execute results against in-order load responses
// onto the single register-file write port and tracks pending load targets.
module riscv_writeback
    import riscv_pkg::*;
#(
    parameter int unsigned LD_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        exe_valid_in,
    output logic        exe_ready_out,
    input  logic [4:0]  exe_rd_in,
    input  logic [31:0] exe_data_in,
    input  logic        ld_issue_valid_in,
    output logic        ld_issue_ready_out,
    input  logic [4:0]  ld_rd_in,
    input  logic [2:0]  ld_funct3_in,
    input  logic [1:0]  ld_offset_in,
    input  logic        mem_rvalid_in,
    input  logic [31:0] mem_rdata_in,
    output logic        rf_we_out,
    output logic [4:0]  rf_rd_out,
    output logic [31:0] rf_wd_out,
    output logic [31:0] pending_out,
    output logic        protocol_err_out
);

    localparam int PW = $clog2(LD_DEPTH);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Execute holds its result while exe_ready_out is low; ld_issue_ready_out
    // depends only on FIFO state; memory responses are never back-pressured.

    ld_entry_t   fifo [LD_DEPTH];
    logic [PW:0] head;
    logic [PW:0] tail;
    logic [PW:0] count;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        exe_accept;
    ld_entry_t   head_entry;
    logic [31:0] align_data;
    logic        align_illegal;
    logic [PW-1:0] rel;

    assign empty = (head == tail);
    assign full  = (head[PW] != tail[PW]) && (head[PW-1:0] == tail[PW-1:0]);
    assign count = tail - head;

    assign ld_issue_ready_out = !full;
    assign exe_ready_out      = !mem_rvalid_in;

    assign push       = ld_issue_valid_in && !full;
    assign pop        = mem_rvalid_in && !empty;
    assign exe_accept = exe_valid_in && !mem_rvalid_in;

    assign head_entry = fifo[head[PW-1:0]];

    riscv_load_align u_align (
        .funct3  (head_entry.funct3),
        .offset  (head_entry.offset),
        .rdata   (mem_rdata_in),
        .data    (align_data),
        .illegal (align_illegal)
    );

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        pending_out = '0;
        rel         = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            rel = PW'(i) - head[PW-1:0];
            if ({1'b0, rel} < count) begin
                pending_out = pending_out | rd_onehot(fifo[i].rd);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo[tail[PW-1:0]] <= '{rd: ld_rd_in, funct3: ld_funct3_in, offset: ld_offset_in};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
        end
    end

    // Memory responses win the port; an orphan response is flagged and dropped.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rf_we_out        <= 1'b0;
            rf_rd_out        <= '0;
            rf_wd_out        <= '0;
            protocol_err_out <= 1'b0;
        end else begin
            rf_we_out <= 1'b0;
            if (pop) begin
                rf_we_out <= (head_entry.rd != 5'd0);
                rf_rd_out <= head_entry.rd;
                rf_wd_out <= align_illegal ? 32'd0 : align_data;
                if (align_illegal) protocol_err_out <= 1'b1;
            end else if (mem_rvalid_in) begin
                protocol_err_out <= 1'b1;
            end else if (exe_accept) begin
                rf_we_out <= (exe_rd_in != 5'd0);
                rf_rd_out <= exe_rd_in;
                rf_wd_out <= exe_data_in;
            end
        end
    end

endmodule

// File: tb/tb_riscv_writeback.sv
// Bench for riscv_writeback: directed feature tasks plus a randomized run
// against a queue-based reference model of loads and execute results.
module tb_riscv_writeback;

    localparam int DEPTH = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        exe_valid_in = 1'b0;
    logic        exe_ready_out;
    logic [4:0]  exe_rd_in = '0;
    logic [31:0] exe_data_in = '0;
    logic        ld_issue_valid_in = 1'b0;
    logic        ld_issue_ready_out;
    logic [4:0]  ld_rd_in = '0;
    logic [2:0]  ld_funct3_in = '0;
    logic [1:0]  ld_offset_in = '0;
    logic        mem_rvalid_in = 1'b0;
    logic [31:0] mem_rdata_in = '0;
    logic        rf_we_out;
    logic [4:0]  rf_rd_out;
    logic [31:0] rf_wd_out;
    logic [31:0] pending_out;
    logic        protocol_err_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } mdl_t;

    mdl_t        mq[$];
    logic [36:0] exp_q[$];

    riscv_writeback #(.LD_DEPTH(DEPTH)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .exe_valid_in       (exe_valid_in),
        .exe_ready_out      (exe_ready_out),
        .exe_rd_in          (exe_rd_in),
        .exe_data_in        (exe_data_in),
        .ld_issue_valid_in  (ld_issue_valid_in),
        .ld_issue_ready_out (ld_issue_ready_out),
        .ld_rd_in           (ld_rd_in),
        .ld_funct3_in       (ld_funct3_in),
        .ld_offset_in       (ld_offset_in),
        .mem_rvalid_in      (mem_rvalid_in),
        .mem_rdata_in       (mem_rdata_in),
        .rf_we_out          (rf_we_out),
        .rf_rd_out          (rf_rd_out),
        .rf_wd_out          (rf_wd_out),
        .pending_out        (pending_out),
        .protocol_err_out   (protocol_err_out)
    );

    // Clock and reset
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        exe_valid_in = 1'b0;
        ld_issue_valid_in = 1'b0;
        mem_rvalid_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
        mq.delete();
    endtask

    // Driver tasks
    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        ld_issue_valid_in = 1'b1;
        ld_rd_in = rd;
        ld_funct3_in = f3;
        ld_offset_in = off;
        tick();
        ld_issue_valid_in = 1'b0;
    endtask

    task automatic respond(input logic [31:0] word);
        mem_rvalid_in = 1'b1;
        mem_rdata_in = word;
        tick();
        mem_rvalid_in = 1'b0;
    endtask

    // Reference: lane selection and extension by plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w, output logic illegal);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        illegal = 1'b0;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            3'b010:  return w;
            default: begin illegal = 1'b1; return 32'd0; end
        endcase
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (rf_we_out !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we_out); end
        checks++; if (rf_rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rf_rd_out); end
        checks++; if (rf_wd_out !== 32'd0) begin errors++; $display("FAIL reset_wd got %h want 0", rf_wd_out); end
        checks++; if (pending_out !== 32'd0) begin errors++; $display("FAIL reset_pending got %h want 0", pending_out); end
        checks++; if (protocol_err_out !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", protocol_err_out); end
        checks++; if (ld_issue_ready_out !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b want 1", ld_issue_ready_out); end
    endtask

    task automatic test_exe();
        exe_valid_in = 1'b1;
        exe_rd_in = 5'd5;
        exe_data_in = 32'h1234_5678;
        #1;
        checks++; if (exe_ready_out !== 1'b1) begin errors++; $display("FAIL exe_ready got %b want 1", exe_ready_out); end
        tick();
        exe_valid_in = 1'b0;
        checks++; if (rf_we_out !== 1'b1) begin errors++; $display("FAIL exe_we got %b want 1", rf_we_out); end
        checks++; if (rf_rd_out !== 5'd5) begin errors++; $display("FAIL exe_rd got %0d want 5", rf_rd_out); end
        checks++; if (rf_wd_out !== 32'h1234_5678) begin errors++; $display("FAIL exe_wd got %h want 12345678", rf_wd_out); end
        tick();
        checks++; if (rf_we_out !== 1'b0) begin errors++; $display("FAIL exe_pulse got %b want 0", rf_we_out); end
    endtask

    task automatic test_load_align();
        logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b001};
        logic [1:0]  offs [3] = '{2'd3, 2'd3, 2'd2};
        logic [31:0] want [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
        for (int i = 0; i < 3; i++) begin
            issue(5'd7, f3s[i], offs[i]);
            checks++; if (pending_out !== 32'h80) begin errors++; $display("FAIL align_pending%0d got %h want 00000080", i, pending_out); end
            respond(32'h80FF_0000);
            checks++; if (rf_we_out !== 1'b1 || rf_rd_out !== 5'd7) begin errors++; $display("FAIL align_we%0d got we=%b rd=%0d want we=1 rd=7", i, rf_we_out, rf_rd_out); end
            checks++; if (rf_wd_out !== want[i]) begin errors++; $display("FAIL align_wd%0d got %h want %h", i, rf_wd_out, want[i]); end
            checks++; if (pending_out !== 32'd0) begin errors++; $display("FAIL align_clear%0d got %h want 0", i, pending_out); end
        end
    endtask

    task automatic test_two_loads();
        issue(5'd3, 3'b010, 2'd0);
        issue(5'd4, 3'b010, 2'd0);
        checks++; if (ld_issue_ready_out !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ld_issue_ready_out); end
        checks++; if (pending_out !== 32'h18) begin errors++; $display("FAIL full_pending got %h want 00000018", pending_out); end
        respond(32'hAAAA_0003);
        checks++; if (rf_rd_out !== 5'd3 || rf_wd_out !== 32'hAAAA_0003) begin errors++; $display("FAIL order_first got rd=%0d wd=%h want rd=3 wd=aaaa0003", rf_rd_out, rf_wd_out); end
        checks++; if (pending_out !== 32'h10) begin errors++; $display("FAIL order_pending got %h want 00000010", pending_out); end
        respond(32'hBBBB_0004);
        checks++; if (rf_rd_out !== 5'd4 || rf_wd_out !== 32'hBBBB_0004) begin errors++; $display("FAIL order_second got rd=%0d wd=%h want rd=4 wd=bbbb0004", rf_rd_out, rf_wd_out); end
        checks++; if (pending_out !== 32'd0 || ld_issue_ready_out !== 1'b1) begin errors++; $display("FAIL drain got pending=%h ready=%b want 0/1", pending_out, ld_issue_ready_out); end
    endtask

    task automatic test_back_to_back();
        issue(5'd9, 3'b010, 2'd0);
        exe_valid_in = 1'b1;
        exe_rd_in = 5'd10;
        exe_data_in = 32'h0BAD_BEEF;
        mem_rvalid_in = 1'b1;
        mem_rdata_in = 32'hCAFE_F00D;
        #1;
        checks++; if (exe_ready_out !== 1'b0) begin errors++; $display("FAIL arb_ready got %b want 0", exe_ready_out); end
        tick();
        mem_rvalid_in = 1'b0;
        checks++; if (rf_we_out !== 1'b1 || rf_rd_out !== 5'd9 || rf_wd_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL arb_load got we=%b rd=%0d wd=%h want 1/9/cafef00d", rf_we_out, rf_rd_out, rf_wd_out); end
        tick();
        exe_valid_in = 1'b0;
        checks++; if (rf_we_out !== 1'b1 || rf_rd_out !== 5'd10 || rf_wd_out !== 32'h0BAD_BEEF) begin errors++; $display("FAIL arb_exe got we=%b rd=%0d wd=%h want 1/10/0badbeef", rf_we_out, rf_rd_out, rf_wd_out); end
    endtask

    task automatic test_rd0();
        issue(5'd0, 3'b010, 2'd0);
        respond(32'h1111_1111);
        checks++; if (rf_we_out !== 1'b0) begin errors++; $display("FAIL rd0_we got %b want 0", rf_we_out); end
        issue(5'd2, 3'b100, 2'd1);
        respond(32'h0000_AB00);
        checks++; if (rf_we_out !== 1'b1 || rf_rd_out !== 5'd2 || rf_wd_out !== 32'hAB) begin errors++; $display("FAIL rd0_pop got we=%b rd=%0d wd=%h want 1/2/000000ab", rf_we_out, rf_rd_out, rf_wd_out); end
    endtask

    task automatic test_errors();
        do_reset();
        respond(32'h5555_5555);
        checks++; if (rf_we_out !== 1'b0 || protocol_err_out !== 1'b1) begin errors++; $display("FAIL orphan got we=%b err=%b want 0/1", rf_we_out, protocol_err_out); end
        tick();
        checks++; if (protocol_err_out !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", protocol_err_out); end
        do_reset();
        checks++; if (protocol_err_out !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", protocol_err_out); end
        issue(5'd6, 3'b011, 2'd0);
        respond(32'hFFFF_FFFF);
        checks++; if (rf_we_out !== 1'b1 || rf_rd_out !== 5'd6 || rf_wd_out !== 32'd0) begin errors++; $display("FAIL illegal_write got we=%b rd=%0d wd=%h want 1/6/0", rf_we_out, rf_rd_out, rf_wd_out); end
        checks++; if (protocol_err_out !== 1'b1) begin errors++; $display("FAIL illegal_err got %b want 1", protocol_err_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(5'd12, 3'b010, 2'd0);
        checks++; if (pending_out !== 32'h1000) begin errors++; $display("FAIL mid_pending got %h want 00001000", pending_out); end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        checks++; if (pending_out !== 32'd0 || ld_issue_ready_out !== 1'b1) begin errors++; $display("FAIL mid_flush got pending=%h ready=%b want 0/1", pending_out, ld_issue_ready_out); end
        respond(32'h7777_7777);
        checks++; if (rf_we_out !== 1'b0 || protocol_err_out !== 1'b1) begin errors++; $display("FAIL stale got we=%b err=%b want 0/1", rf_we_out, protocol_err_out); end
    endtask

    // Scoreboard-driven random traffic.
    task automatic test_random();
        logic [2:0]  legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic        held;
        logic        exp_we;
        logic        ill;
        logic [31:0] d;
        logic [36:0] e;
        int          size_before;
        mdl_t        m;
        do_reset();
        held = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!held) begin
                exe_valid_in = ($urandom_range(0, 1) == 1);
                exe_rd_in    = 5'($urandom_range(0, 31));
                exe_data_in  = $urandom;
            end
            ld_issue_valid_in = ($urandom_range(0, 2) == 0);
            ld_rd_in          = 5'($urandom_range(0, 31));
            ld_funct3_in      = legal[$urandom_range(0, 4)];
            ld_offset_in      = 2'($urandom_range(0, 3));
            mem_rvalid_in     = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
            mem_rdata_in      = $urandom;
            #1;
            checks++; if (ld_issue_ready_out !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, ld_issue_ready_out, mq.size() < DEPTH); end
            checks++; if (exe_ready_out !== !mem_rvalid_in) begin errors++; $display("FAIL rnd_exe_ready c=%0d got %b want %b", c, exe_ready_out, !mem_rvalid_in); end
            checks++; if (pending_out !== model_pending()) begin errors++; $display("FAIL rnd_pending c=%0d got %h want %h", c, pending_out, model_pending()); end
            size_before = mq.size();
            exp_we = 1'b0;
            if (mem_rvalid_in) begin
                m = mq.pop_front();
                d = ref_load(m.f3, m.off, mem_rdata_in, ill);
                exp_we = (m.rd != 5'd0);
                if (exp_we) exp_q.push_back({m.rd, d});
            end else if (exe_valid_in) begin
                exp_we = (exe_rd_in != 5'd0);
                if (exp_we) exp_q.push_back({exe_rd_in, exe_data_in});
            end
            held = exe_valid_in && mem_rvalid_in;
            if (ld_issue_valid_in && size_before < DEPTH) begin
                m.rd = ld_rd_in; m.f3 = ld_funct3_in; m.off = ld_offset_in;
                mq.push_back(m);
            end
            tick();
            checks++; if (rf_we_out !== exp_we) begin errors++; $display("FAIL rnd_we c=%0d got %b want %b", c, rf_we_out, exp_we); end
            if (exp_we && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if ({rf_rd_out, rf_wd_out} !== e) begin errors++; $display("FAIL rnd_write c=%0d got rd=%0d wd=%h want rd=%0d wd=%h", c, rf_rd_out, rf_wd_out, e[36:32], e[31:0]); end
            end
        end
        exe_valid_in = 1'b0;
        ld_issue_valid_in = 1'b0;
        mem_rvalid_in = 1'b0;
        checks++; if (protocol_err_out !== 1'b0) begin errors++; $display("FAIL rnd_err got %b want 0", protocol_err_out); end
    endtask

    initial begin
        test_reset();
        test_exe();
        test_load_align();
        test_two_loads();
        test_back_to_back();
        test_rd0();
        test_errors();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
